psg_write_sched: RTL and testbench
==================================

PSG_WRITE_SCHED -- requirements
Module: psg_write_sched

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles psg_D/psg_nCE are valid before psg_nWE falls (range 1..15).
REQ-002 SHALL have parameter HOLD_CYC, default 1: minimum strobe-high cycles after a write before the next write (range 1..15).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64: READY watchdog limit in cycles (used only under REQ-027).
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 nRST  input  1  reset, asynchronous and active-low.
REQ-006 req0_valid / req1_valid  input  1 each  requester has a command byte.
REQ-007 req0_data / req1_data  input  8 each  PSG command byte.
REQ-008 req0_ready / req1_ready  output  1 each  byte accepted this cycle.
REQ-009 psg_D  output  8  PSG data bus.
REQ-010 psg_nCE / psg_nWE  output  1 each  PSG chip enable and write strobe, active-low.
REQ-011 psg_READY  input  1  PSG ready: low while a write is being absorbed.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 grant_id  output  1  requester that owns the current or last write.
REQ-014 err_timeout  output  1  one-cycle pulse on watchdog abort.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> STROBE -> RECOVER -> IDLE.
REQ-016 IDLE: if any valid, arbitrate; the winner's ready is high for exactly that cycle (combinational from IDLE & valid & grant); the byte is captured into a hold register; next state SETUP; no valid -> stay IDLE.
REQ-017 SETUP: psg_D = hold, psg_nCE = 0, psg_nWE = 1 for exactly SETUP_CYC cycles, then STROBE.
REQ-018 STROBE: psg_nCE = 0, psg_nWE = 0; leave for RECOVER on the first cycle psg_READY is sampled 0.
REQ-019 RECOVER: psg_nCE = psg_nWE = 1, psg_D held; leave for IDLE only when psg_READY = 1 and at least HOLD_CYC cycles have elapsed in RECOVER.
REQ-020 Minimum byte period SHALL be 1 + SETUP_CYC + (STROBE cycles) + HOLD_CYC clocks; a ready SHALL never be asserted outside IDLE.
REQ-021 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-022 Tone-pair lock: when the granted byte has bit7 = 1, bit4 = 0 and bits6:5 != 3, the lock SHALL be set to that requester; while locked, only that requester may be granted; the lock clears when its next byte is granted.
REQ-023 While locked and the owner's valid is low, the scheduler SHALL stay IDLE even if the other requester is valid.
REQ-024 A valid drop while not granted SHALL have no effect; data SHALL be sampled only in the accept cycle.

Reset
REQ-025 On nRST low, asynchronously: state IDLE, psg_nCE = psg_nWE = 1, psg_D = 0, both readys 0, busy 0, grant_id 0, err_timeout 0, lock cleared, last-grant = 1 (req0 wins first).
REQ-026 Reset mid-write SHALL deassert the strobes immediately; the interrupted byte is discarded and never replayed.

Configuration
REQ-027 With PSG_SCHED_TIMEOUT_EN defined: if STROBE + RECOVER together exceed TIMEOUT_CYC cycles, force psg_nCE = psg_nWE = 1, return to IDLE, pulse err_timeout, and clear the lock. Without the macro: wait indefinitely, and err_timeout is tied 0 (the port is kept).

Structure
REQ-028 Package psg_pkg SHALL hold the state enum and the command-byte field constants (LATCH_BIT = 7, TYPE_BIT = 4, CH_MSB/LSB = 6/5, NOISE_CH = 3).
REQ-029 Round-robin plus lock selection SHALL be the sub-module psg_rr_arb; the FSM and bus timing stay in psg_write_sched.

Verification
REQ-030 Single write: req0 sends 0x9F, and the PSG model pulls READY low 2 cycles after nWE falls -> psg_D = 0x9F, nCE low 1 cycle before nWE, one accept pulse, and busy returns low.
REQ-031 Contention: both valid continuously (req0 0x90, req1 0xB0) -> grants alternate 0,1,0,1 starting with req0.
REQ-032 Lock: req0 sends 0x8E then 0x0F while req1 holds 0xA1 -> bus order 0x8E, 0x0F, 0xA1.
REQ-033 Lock stall: req0 sends 0x85 then drops valid 20 cycles while req1 is valid -> no write for 20 cycles; req0's next byte goes first.
REQ-034 Timeout (macro on, TIMEOUT_CYC = 8): READY is held high -> strobes release after 8 cycles, err_timeout pulses once, and the next request is serviced.
REQ-035 Reset during STROBE -> nWE and nCE high in the same cycle, state IDLE, and no readys asserted.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared types and command-byte field positions for the PSG write scheduler.
package psg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int LATCH_BIT = 7;
  localparam int TYPE_BIT  = 4;
  localparam int CH_MSB    = 6;
  localparam int CH_LSB    = 5;
  localparam logic [1:0] NOISE_CH = 2'd3;

  // A tone-frequency latch byte is followed by a data byte that must stay paired with it.
  function automatic logic is_tone_latch(input logic [7:0] b);
    return b[LATCH_BIT] && !b[TYPE_BIT] && (b[CH_MSB:CH_LSB] != NOISE_CH);
  endfunction

endpackage

// File: rtl/psg_write_sched_if.sv
// Requester handshakes and PSG bus pins shared by the scheduler and its environment.
// Handshake: a byte transfers on a rising clock edge where reqN_valid and reqN_ready are both high;
// reqN_ready is only ever high while the scheduler is IDLE, and data need only be stable in that cycle.
interface psg_write_sched_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [7:0] psg_D;
  logic       psg_nCE;
  logic       psg_nWE;
  logic       psg_READY;
  logic       busy;
  logic       grant_id;
  logic       err_timeout;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, psg_READY,
    input  req0_ready, req1_ready, psg_D, psg_nCE, psg_nWE, busy, grant_id, err_timeout
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, psg_READY,
    output req0_ready, req1_ready, psg_D, psg_nCE, psg_nWE, busy, grant_id, err_timeout
  );
endinterface

// File: rtl/psg_rr_arb.sv
// Round-robin arbiter between two PSG requesters with a tone-pair lock that keeps
// a latch byte and its following data byte from the same requester back to back.
module psg_rr_arb
  import psg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept_en,
  input  logic       clear_lock,
  input  logic       valid0,
  input  logic       valid1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       grant_valid,
  output logic       grant_id,
  output logic [7:0] grant_data
);

  logic last_grant;
  logic lock_active;
  logic lock_owner;

  // While locked the other requester is ignored, even if the owner is not valid.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (lock_active) begin
      grant_id    = lock_owner;
      grant_valid = lock_owner ? valid1 : valid0;
    end else if (valid0 && valid1) begin
      grant_id    = ~last_grant;
      grant_valid = 1'b1;
    end else if (valid0) begin
      grant_valid = 1'b1;
    end else if (valid1) begin
      grant_id    = 1'b1;
      grant_valid = 1'b1;
    end
  end

  assign grant_data = grant_id ? data1 : data0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
    end else if (clear_lock) begin
      lock_active <= 1'b0;
    end else if (accept_en && grant_valid) begin
      last_grant <= grant_id;
      if (lock_active) begin
        lock_active <= 1'b0;
      end else if (is_tone_latch(grant_data)) begin
        lock_active <= 1'b1;
        lock_owner  <= grant_id;
      end
    end
  end

endmodule

// File: rtl/psg_write_sched.sv
// Two-requester write scheduler driving a PSG bus with setup/strobe/recover timing.
// Optional READY watchdog enabled by defining PSG_SCHED_TIMEOUT_EN.
module psg_write_sched
  import psg_pkg::*;
#(
  parameter int SETUP_CYC   = 1,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  psg_write_sched_if.slave  bus,
  output state_t            dbg_state
);

  localparam int CW = $clog2(((TIMEOUT_CYC > 16) ? TIMEOUT_CYC : 16) + 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [7:0]     d_q;
  logic           nce_q;
  logic           nwe_q;
  logic           gid_q;
  logic           grant_valid;
  logic           grant_id;
  logic [7:0]     grant_data;
  logic           accept;
  logic           strobe_done;
  logic           recover_done;
  logic           abort;

  psg_rr_arb u_arb (
    .clk         (CLK),
    .rst_n       (nRST),
    .accept_en   (state == IDLE),
    .clear_lock  (abort),
    .valid0      (bus.req0_valid),
    .valid1      (bus.req1_valid),
    .data0       (bus.req0_data),
    .data1       (bus.req1_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_data  (grant_data)
  );

  // Gated by nRST so no ready can be seen while reset is held.
  assign accept         = (state == IDLE) && grant_valid && nRST;
  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept && grant_id;

  assign strobe_done  = (state == STROBE) && !bus.psg_READY;
  assign recover_done = (state == RECOVER) && bus.psg_READY && (cnt >= CW'(HOLD_CYC - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      d_q   <= 8'h00;
      nce_q <= 1'b1;
      nwe_q <= 1'b1;
      gid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            d_q   <= grant_data;
            gid_q <= grant_id;
            nce_q <= 1'b0;
            cnt   <= '0;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CW'(SETUP_CYC - 1)) begin
            nwe_q <= 1'b0;
            cnt   <= '0;
            state <= STROBE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STROBE: begin
          if (strobe_done) begin
            nce_q <= 1'b1;
            nwe_q <= 1'b1;
            cnt   <= '0;
            state <= RECOVER;
          end
        end
        RECOVER: begin
          if (recover_done) begin
            state <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (abort) begin
        nce_q <= 1'b1;
        nwe_q <= 1'b1;
        state <= IDLE;
      end
    end
  end

`ifdef PSG_SCHED_TIMEOUT_EN
  logic [CW-1:0] wd;
  logic          err_q;

  // Watchdog spans STROBE and RECOVER together; a normal exit on the limit cycle wins.
  assign abort = ((state == STROBE) || (state == RECOVER)) &&
                 (wd >= CW'(TIMEOUT_CYC - 1)) && !strobe_done && !recover_done;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
      if (state == SETUP) begin
        wd <= '0;
      end else if ((state == STROBE) || (state == RECOVER)) begin
        wd <= wd + 1'b1;
      end
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign abort           = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.psg_D    = d_q;
  assign bus.psg_nCE  = nce_q;
  assign bus.psg_nWE  = nwe_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = (state != IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_psg_write_sched.sv
// Self-checking bench for psg_write_sched: PSG READY model, requester drivers,
// bus-order scoreboard, and directed scenarios for timing, arbitration, lock, timeout and reset.
module tb_psg_write_sched;
  import psg_pkg::*;

  localparam int SETUP_CYC   = 1;
  localparam int HOLD_CYC    = 1;
  localparam int TIMEOUT_CYC = 8;

  logic   CLK;
  logic   nRST;
  state_t dbg_state;

  psg_write_sched_if bus();

  psg_write_sched #(
    .SETUP_CYC   (SETUP_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- PSG READY model ----------------
  logic rdy;
  bit   model_en = 1'b1;
  int   ready_delay = 2;
  int   low_len = 1;
  int   wcnt;
  int   lcnt;

  assign bus.psg_READY = rdy;

  always @(negedge CLK) begin
    if (!nRST || !model_en) begin
      rdy  = 1'b1;
      wcnt = 0;
      lcnt = 0;
    end else if (!bus.psg_nWE) begin
      lcnt = 0;
      wcnt++;
      if (wcnt >= ready_delay) rdy = 1'b0;
    end else begin
      wcnt = 0;
      if (!rdy) begin
        lcnt++;
        if (lcnt >= low_len) rdy = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / bus monitor ----------------
  logic [8:0] exp_q[$];
  int wr_count = 0;
  int acc0 = 0;
  int acc1 = 0;
  int err_cnt = 0;
  int setup_run = 0;
  int low_run = 0;
  int last_low_run = 0;
  bit nwe_prev = 1'b1;

  always @(negedge CLK) begin
    logic [8:0] e;
    if (!nRST) begin
      nwe_prev  = 1'b1;
      setup_run = 0;
      low_run   = 0;
    end else begin
      if (bus.req0_ready) acc0++;
      if (bus.req1_ready) acc1++;
      if (bus.err_timeout) err_cnt++;
      if (nwe_prev && !bus.psg_nWE) begin
        wr_count++;
        check("setup_len", setup_run, SETUP_CYC);
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_id", bus.grant_id, e[8]);
          check("wr_data", bus.psg_D, e[7:0]);
        end
      end
      if (!bus.psg_nCE && bus.psg_nWE) setup_run++;
      else if (bus.psg_nCE) setup_run = 0;
      if (!bus.psg_nWE) begin
        low_run++;
      end else begin
        if (!nwe_prev) last_low_run = low_run;
        low_run = 0;
      end
      nwe_prev = bus.psg_nWE;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit id, input logic [7:0] d);
    bit got = 1'b0;
    @(posedge CLK);
    #1;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_data = d; end
    else    begin bus.req0_valid = 1'b1; bus.req0_data = d; end
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge CLK);
      got = id ? bus.req1_ready : bus.req0_ready;
    end
    if (!got) check("accept_wait", got, 1);
    else begin
      @(posedge CLK);
      #1;
    end
    // Data is scrambled after the accept edge so late sampling would show up on the bus.
    if (id) begin bus.req1_valid = 1'b0; bus.req1_data = 8'($urandom_range(0, 255)); end
    else    begin bus.req0_valid = 1'b0; bus.req0_data = 8'($urandom_range(0, 255)); end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge CLK);
      done = !bus.busy && (exp_q.size() == 0);
    end
    check("idle_wait", done, 1);
  endtask

  task automatic apply_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    model_en = 1'b1;
    ready_delay = 2;
    low_len = 1;
    @(negedge CLK);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.delete();
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic push(input bit id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- scenarios ----------------
  initial begin
    int a0, w0, e0;
    bit seen;
    logic [7:0] d;

    nRST = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_data  = 8'h00;
    #2 nRST = 1'b0;
    #1;
    check("rst_nce", bus.psg_nCE, 1);
    check("rst_nwe", bus.psg_nWE, 1);
    check("rst_d", bus.psg_D, 8'h00);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_gid", bus.grant_id, 0);
    check("rst_err", bus.err_timeout, 0);
    check("rst_state", dbg_state, IDLE);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Single write with READY falling two cycles into the strobe.
    apply_reset();
    a0 = acc0;
    push(1'b0, 8'h9F);
    send(1'b0, 8'h9F);
    wait_idle();
    check("single_strobe_len", last_low_run, 2);
    check("single_accepts", acc0 - a0, 1);
    check("single_busy", bus.busy, 0);
    check("single_d_held", bus.psg_D, 8'h9F);

    // Contention: alternation starting with req0.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 8'h90);
      push(1'b1, 8'hB0);
    end
    fork
      begin for (int i = 0; i < 3; i++) send(1'b0, 8'h90); end
      begin for (int i = 0; i < 3; i++) send(1'b1, 8'hB0); end
    join
    wait_idle();

    // Tone-pair lock keeps 0x8E/0x0F together ahead of req1.
    apply_reset();
    push(1'b0, 8'h8E);
    push(1'b0, 8'h0F);
    push(1'b1, 8'hA1);
    fork
      begin send(1'b0, 8'h8E); send(1'b0, 8'h0F); end
      begin send(1'b1, 8'hA1); end
    join
    wait_idle();

    // Lock stall: owner silent for 20 cycles, other requester waits.
    apply_reset();
    push(1'b0, 8'h85);
    push(1'b0, 8'h1A);
    push(1'b1, 8'hB0);
    w0 = wr_count;
    fork
      begin
        send(1'b0, 8'h85);
        repeat (20) @(negedge CLK);
        check("stall_writes", wr_count - w0, 1);
        check("stall_busy", bus.busy, 0);
        send(1'b0, 8'h1A);
      end
      begin send(1'b1, 8'hB0); end
    join
    wait_idle();

`ifdef PSG_SCHED_TIMEOUT_EN
    // READY never falls: watchdog aborts a lock-setting byte, then req1 is still serviced.
    apply_reset();
    model_en = 1'b0;
    e0 = err_cnt;
    push(1'b0, 8'h80);
    send(1'b0, 8'h80);
    wait_idle();
    repeat (3) @(negedge CLK);
    check("to_strobe_len", last_low_run, TIMEOUT_CYC);
    check("to_err_pulses", err_cnt - e0, 1);
    check("to_nce", bus.psg_nCE, 1);
    model_en = 1'b1;
    push(1'b1, 8'h55);
    send(1'b1, 8'h55);
    wait_idle();
`endif

    // Reset while strobing: strobes release at once, byte is not replayed.
    apply_reset();
    model_en = 1'b0;
    e0 = err_cnt;
    push(1'b1, 8'h3C);
    send(1'b1, 8'h3C);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      seen = !bus.psg_nWE;
    end
    check("rm_strobe_seen", seen, 1);
    repeat (3) @(negedge CLK);
    check("rm_strobe_held", bus.psg_nWE, 0);
`ifndef PSG_SCHED_TIMEOUT_EN
    repeat (20) @(negedge CLK);
    check("rm_stuck_nwe", bus.psg_nWE, 0);
    check("rm_no_err", err_cnt - e0, 0);
`endif
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h11;
    #2 nRST = 1'b0;
    #1;
    check("rm_nwe", bus.psg_nWE, 1);
    check("rm_nce", bus.psg_nCE, 1);
    check("rm_state", dbg_state, IDLE);
    check("rm_ready0", bus.req0_ready, 0);
    check("rm_busy", bus.busy, 0);
    bus.req0_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    w0 = wr_count;
    repeat (15) @(negedge CLK);
    check("rm_no_replay", wr_count - w0, 0);
    check("rm_q_empty", exp_q.size(), 0);

    // Random bytes from one requester under varying READY timing.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      ready_delay = $urandom_range(1, 3);
      low_len     = $urandom_range(1, 3);
      d = 8'($urandom_range(0, 255));
      push(1'b1, d);
      send(1'b1, d);
      wait_idle();
    end

    check("final_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
